// File: rtl/iob_sync_fifo_ctrl_if.sv
// FIFO user-side bundle: push/pop requests, returned pop data and occupancy status.
// The almost_full/almost_empty flags exist only when IOB_FIFO_ALMOST_EN is defined.
interface iob_sync_fifo_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              push;
   logic [DATA_W-1:0] push_data;
   logic              pop;
   logic [DATA_W-1:0] pop_data;
   logic              pop_valid;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   level;
   logic              push_err;
   logic              pop_err;
`ifdef IOB_FIFO_ALMOST_EN
   logic              almost_full;
   logic              almost_empty;

   modport master (
      output push, push_data, pop,
      input  pop_data, pop_valid, full, empty, level, push_err, pop_err,
      input  almost_full, almost_empty
   );

   modport slave (
      input  push, push_data, pop,
      output pop_data, pop_valid, full, empty, level, push_err, pop_err,
      output almost_full, almost_empty
   );
`else
   modport master (
      output push, push_data, pop,
      input  pop_data, pop_valid, full, empty, level, push_err, pop_err
   );

   modport slave (
      input  push, push_data, pop,
      output pop_data, pop_valid, full, empty, level, push_err, pop_err
   );
`endif
endinterface

// File: rtl/iob_sync_fifo_ctrl.sv
// Single-clock FIFO controller driving a two-port RAM; optional almost flags via IOB_FIFO_ALMOST_EN.
// Latency: RAM enables/addresses are combinational; pop_data/pop_valid arrive one cycle after an accepted pop.
// Backpressure: push while full or pop while empty is dropped and reported by a one-cycle err pulse.
module iob_sync_fifo_ctrl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4
`ifdef IOB_FIFO_ALMOST_EN
   ,
   parameter int AFULL_TH  = 2**ADDR_W - 2,
   parameter int AEMPTY_TH = 1
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   iob_sync_fifo_ctrl_if.slave  fifo_if,
   output logic                 ram_w_en_o,
   output logic [ADDR_W-1:0]    ram_w_addr_o,
   output logic [DATA_W-1:0]    ram_data_in_o,
   output logic                 ram_r_en_o,
   output logic [ADDR_W-1:0]    ram_r_addr_o,
   input  logic [DATA_W-1:0]    ram_data_out_i
);

   localparam int              LVL_W    = ADDR_W + 1;
   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
`ifdef IOB_FIFO_ALMOST_EN
   localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AFULL_TH);
   localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AEMPTY_TH);
`endif

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              pop_valid_q, pop_valid_d;
   logic              push_err_q, push_err_d;
   logic              pop_err_q, pop_err_d;
`ifdef IOB_FIFO_ALMOST_EN
   logic              afull_q, afull_d;
   logic              aempty_q, aempty_d;
`endif

   logic              push_ok;
   logic              pop_ok;

   // Enables are gated by rst_n so a request coincident with reset never touches the RAM.
   always_comb begin
      push_ok     = fifo_if.push & ~full_q & rst_n;
      pop_ok      = fifo_if.pop & ~empty_q & rst_n;

      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      level_d     = level_q;

      if (push_ok) begin
         wptr_d = wptr_q + ADDR_W'(1);
      end
      if (pop_ok) begin
         rptr_d = rptr_q + ADDR_W'(1);
      end

      unique case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      full_d      = (level_d == LVL_FULL);
      empty_d     = (level_d == '0);
      pop_valid_d = pop_ok;
      push_err_d  = fifo_if.push & full_q;
      pop_err_d   = fifo_if.pop & empty_q;
`ifdef IOB_FIFO_ALMOST_EN
      afull_d     = (level_d >= LVL_AF);
      aempty_d    = (level_d <= LVL_AE);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         pop_valid_q <= 1'b0;
         push_err_q  <= 1'b0;
         pop_err_q   <= 1'b0;
`ifdef IOB_FIFO_ALMOST_EN
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
`endif
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         pop_valid_q <= pop_valid_d;
         push_err_q  <= push_err_d;
         pop_err_q   <= pop_err_d;
`ifdef IOB_FIFO_ALMOST_EN
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
`endif
      end
   end

   assign ram_w_en_o        = push_ok;
   assign ram_w_addr_o      = wptr_q;
   assign ram_data_in_o     = fifo_if.push_data;
   assign ram_r_en_o        = pop_ok;
   assign ram_r_addr_o      = rptr_q;

   // RAM read data is registered inside the RAM, so it lines up with pop_valid_q.
   assign fifo_if.pop_data  = ram_data_out_i;
   assign fifo_if.pop_valid = pop_valid_q;
   assign fifo_if.full      = full_q;
   assign fifo_if.empty     = empty_q;
   assign fifo_if.level     = level_q;
   assign fifo_if.push_err  = push_err_q;
   assign fifo_if.pop_err   = pop_err_q;
`ifdef IOB_FIFO_ALMOST_EN
   assign fifo_if.almost_full  = afull_q;
   assign fifo_if.almost_empty = aempty_q;
`endif

   a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
      level_q <= LVL_FULL);
   a_full_decode: assert property (@(posedge clk) disable iff (!rst_n)
      full_q == (level_q == LVL_FULL));
   a_empty_decode: assert property (@(posedge clk) disable iff (!rst_n)
      empty_q == (level_q == '0));
   a_no_both_flags: assert property (@(posedge clk) disable iff (!rst_n)
      !(full_q && empty_q));

endmodule
